wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 96 +++++++++
 tb/tb_wb_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: funnels a GPR write plus an optional HI/LO pair
// through one register-file write port, stalling writeback while it drains.
module wb_port_arbiter #(
    parameter logic [5:0] HI_ADDR = 6'd32,
    parameter logic [5:0] LO_ADDR = 6'd33
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_reg_en,
    input  logic [5:0]  wb_reg_waddr,
    input  logic [31:0] wb_reg_wdata,
    input  logic        wb_double_en,
    input  logic [63:0] wb_MD_result,
    output logic        rf_wen,
    output logic [5:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] md_buf;
    logic [63:0] md_buf_next;
    logic        rf_wen_next;
    logic [5:0]  rf_waddr_next;
    logic [31:0] rf_wdata_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            md_buf   <= 64'd0;
            rf_wen   <= 1'b0;
            rf_waddr <= 6'd0;
            rf_wdata <= 32'd0;
        end else begin
            state    <= state_next;
            md_buf   <= md_buf_next;
            rf_wen   <= rf_wen_next;
            rf_waddr <= rf_waddr_next;
            rf_wdata <= rf_wdata_next;
        end
    end

    // Writes drain in GPR, LO, HI order; r0 keeps its slot but never writes.
    always_comb begin
        state_next    = state;
        md_buf_next   = md_buf;
        rf_wen_next   = 1'b0;
        rf_waddr_next = rf_waddr;
        rf_wdata_next = rf_wdata;
        case (state)
            IDLE: begin
                if (wb_double_en) begin
                    md_buf_next = wb_MD_result;
                end
                if (wb_reg_en) begin
                    rf_wen_next   = (wb_reg_waddr != 6'd0);
                    rf_waddr_next = wb_reg_waddr;
                    rf_wdata_next = wb_reg_wdata;
                    if (wb_double_en) begin
                        state_next = WR_LO;
                    end
                end else if (wb_double_en) begin
                    rf_wen_next   = 1'b1;
                    rf_waddr_next = LO_ADDR;
                    rf_wdata_next = wb_MD_result[31:0];
                    state_next    = WR_HI;
                end
            end
            WR_LO: begin
                rf_wen_next   = 1'b1;
                rf_waddr_next = LO_ADDR;
                rf_wdata_next = md_buf[31:0];
                state_next    = WR_HI;
            end
            WR_HI: begin
                rf_wen_next   = 1'b1;
                rf_waddr_next = HI_ADDR;
                rf_wdata_next = md_buf[63:32];
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wb_stall = (state != IDLE);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios then random traffic,
// compared each cycle against a queue-of-pending-writes reference model.
module tb_wb_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        wb_reg_en;
    logic [5:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata;
    logic        wb_double_en;
    logic [63:0] wb_MD_result;
    logic        rf_wen;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_stall;

    typedef struct {
        logic        wen;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         pending[$];
    logic        exp_wen;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
    int          checks;
    int          errors;
    int          r9_writes;

    wb_port_arbiter #(.HI_ADDR(6'd32), .LO_ADDR(6'd33)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_reg_en    (wb_reg_en),
        .wb_reg_waddr (wb_reg_waddr),
        .wb_reg_wdata (wb_reg_wdata),
        .wb_double_en (wb_double_en),
        .wb_MD_result (wb_MD_result),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .wb_stall     (wb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic reg_en, input logic [5:0] waddr, input logic [31:0] wdata,
                                 input logic double_en, input logic [63:0] md);
        wb_reg_en    = reg_en;
        wb_reg_waddr = waddr;
        wb_reg_wdata = wdata;
        wb_double_en = double_en;
        wb_MD_result = md;
    endtask

    task automatic modelReset();
        pending.delete();
        exp_wen  = 1'b0;
        exp_addr = 6'd0;
        exp_data = 32'd0;
    endtask

    // An instruction is accepted only when nothing is left to drain; it
    // expands into an ordered list of write slots, one slot per edge.
    task automatic modelEdge();
        wr_t w;
        wr_t slots[$];
        if (pending.size() == 0) begin
            if (wb_reg_en) begin
                w.wen = (wb_reg_waddr != 6'd0); w.addr = wb_reg_waddr; w.data = wb_reg_wdata;
                slots.push_back(w);
            end
            if (wb_double_en) begin
                w.wen = 1'b1; w.addr = 6'd33; w.data = wb_MD_result[31:0];
                slots.push_back(w);
                w.wen = 1'b1; w.addr = 6'd32; w.data = wb_MD_result[63:32];
                slots.push_back(w);
            end
            pending = slots;
        end
        if (pending.size() == 0) begin
            exp_wen = 1'b0;
        end else begin
            w        = pending.pop_front();
            exp_wen  = w.wen;
            exp_addr = w.addr;
            exp_data = w.data;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".rf_wen"}, {63'd0, rf_wen}, {63'd0, exp_wen});
        checkOutput({tag, ".wb_stall"}, {63'd0, wb_stall}, {63'd0, (pending.size() != 0)});
        if (exp_wen) begin
            checkOutput({tag, ".rf_waddr"}, {58'd0, rf_waddr}, {58'd0, exp_addr});
            checkOutput({tag, ".rf_wdata"}, {32'd0, rf_wdata}, {32'd0, exp_data});
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        if (rf_wen && rf_waddr == 6'd9) r9_writes++;
        checkAll(tag);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".rf_wen"}, {63'd0, rf_wen}, 64'd0);
        checkOutput({tag, ".rf_waddr"}, {58'd0, rf_waddr}, 64'd0);
        checkOutput({tag, ".rf_wdata"}, {32'd0, rf_wdata}, 64'd0);
        checkOutput({tag, ".wb_stall"}, {63'd0, wb_stall}, 64'd0);
    endtask

    // Directed scenarios first, then random traffic with occasional resets.
    initial begin
        checks    = 0;
        errors    = 0;
        r9_writes = 0;
        resetn    = 1'b0;
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 64'd0);
        modelReset();
        #3;
        checkResetOutputs("reset");
        #9 resetn = 1'b1;

        applyStimulus(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 64'd0);
        step("gpr_only");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 64'd0);
        step("gpr_idle");

        applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 64'h11112222_33334444);
        step("dbl_lo");
        step("dbl_hi");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 64'd0);
        step("dbl_done");

        applyStimulus(1'b1, 6'd7, 32'hA5A5A5A5, 1'b1, 64'h1_00000002);
        step("both_gpr");
        step("both_lo");
        step("both_hi");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 64'd0);
        step("both_done");

        applyStimulus(1'b1, 6'd0, 32'h12345678, 1'b0, 64'd0);
        step("r0_only");
        applyStimulus(1'b1, 6'd0, 32'h12345678, 1'b1, 64'hCAFEF00D_0BADBEEF);
        step("r0_dbl_gpr");
        step("r0_dbl_lo");
        step("r0_dbl_hi");

        applyStimulus(1'b1, 6'd7, 32'h77777777, 1'b1, 64'h44444444_55555555);
        step("hold_gpr");
        applyStimulus(1'b1, 6'd9, 32'h99999999, 1'b0, 64'd0);
        step("hold_lo");
        step("hold_hi");
        step("hold_r9");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 64'd0);
        step("hold_after");
        step("hold_after2");
        checkOutput("r9_once", 64'(r9_writes), 64'd1);

        applyStimulus(1'b1, 6'd3, 32'h33333333, 1'b1, 64'hAAAAAAAA_BBBBBBBB);
        step("rst_mid_gpr");
        applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 64'd0);
        #2 resetn = 1'b0;
        #1;
        modelReset();
        checkResetOutputs("rst_mid");
        #2 resetn = 1'b1;
        step("rst_release");
        step("rst_release2");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63)),
                          32'($urandom),
                          ($urandom_range(0, 2) == 0),
                          {32'($urandom), 32'($urandom)});
            if ($urandom_range(0, 60) == 0) begin
                #2 resetn = 1'b0;
                #1;
                modelReset();
                checkResetOutputs("rnd_reset");
                #2 resetn = 1'b1;
            end
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
